// File: rtl/dec_scan_seq.sv
// dec_scan_seq: N-to-2^N one-hot decoder with enable and an auto-scan sequencer.
// Latency: all outputs registered, visible one cycle after the sampling edge.
// Backpressure: none; a_vld loads unconditionally while en=1. Optional macro DEC_SCAN_BIDIR_EN adds a dir port.
module dec_scan_seq #(
    parameter int N       = 2,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [N-1:0]       a,
    input  logic               a_vld,
    input  logic [DWELL_W-1:0] dwell,
`ifdef DEC_SCAN_BIDIR_EN
    input  logic               dir,
`endif
    output logic [2**N-1:0]    y,
    output logic [N-1:0]       idx,
    output logic               wrap
);

    localparam int W = 2**N;
    localparam logic [N-1:0]       IDX_ONE = 1;
    localparam logic [DWELL_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]       y_q, y_d;
    logic               wrap_q, wrap_d;

    // Scan direction: decrement only exists in the bidirectional build.
    logic dir_w;
`ifdef DEC_SCAN_BIDIR_EN
    assign dir_w = dir;
`else
    assign dir_w = 1'b0;
`endif

    logic [N-1:0] idx_step;
    logic         step_wrap;

    // Candidate next index for a scheduled advance, and whether that advance wraps.
    always_comb begin
        idx_step  = idx_q + IDX_ONE;
        step_wrap = (idx_q == {N{1'b1}});
        if (dir_w) begin
            idx_step  = idx_q - IDX_ONE;
            step_wrap = (idx_q == {N{1'b0}});
        end
    end

    // Next-state, index, dwell counter and one-hot output computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        y_d     = '0;
        if (!en) begin
            // Disabled: blank outputs, keep idx so re-enable resumes in place.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            state_d = mode ? SCAN : DECODE;
            if (a_vld) begin
                // A load always wins over a scheduled advance and never pulses wrap.
                idx_d = a;
                cnt_d = '0;
            end else if (state_q == SCAN && mode) begin
                // Live compare against dwell: lowering dwell below cnt lets cnt roll over.
                if (cnt_q == dwell) begin
                    idx_d  = idx_step;
                    cnt_d  = '0;
                    wrap_d = step_wrap;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                // Entering from IDLE/DECODE or freezing on SCAN->DECODE: restart dwell.
                cnt_d = '0;
            end
            y_d[idx_d] = 1'b1;
        end
    end

    // State register with synchronous reset that overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// tb_dec_scan_seq: directed self-checking bench for dec_scan_seq with N=2, DWELL_W=4.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// A negedge monitor checks the one-hot invariant every cycle.
module tb_dec_scan_seq;

    logic       clk = 1'b0;
    logic       rst, en, mode, a_vld;
    logic [1:0] a;
    logic [3:0] dwell;
    logic       dir;
    logic [3:0] y;
    logic [1:0] idx;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_scan_seq #(.N(2), .DWELL_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .a     (a),
        .a_vld (a_vld),
        .dwell (dwell),
`ifdef DEC_SCAN_BIDIR_EN
        .dir   (dir),
`endif
        .y     (y),
        .idx   (idx),
        .wrap  (wrap)
    );

    // Output invariant: y is zero or exactly 1<<idx.
    always @(negedge clk) begin
        logic [3:0] onehot;
        onehot = 4'b0000;
        onehot[idx] = 1'b1;
        checks++;
        if (y !== 4'b0000 && y !== onehot) begin
            errors++;
            $display("FAIL invariant: y=%b idx=%0d required 0000 or %b", y, idx, onehot);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (y !== 4'b0000 || idx !== 2'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset: y=%b idx=%0d wrap=%b required 0000/0/0", y, idx, wrap);
        end
        rst = 1'b0;
    endtask

    task automatic test_decode();
        en = 1'b1; mode = 1'b0; a = 2'd2; a_vld = 1'b1;
        step();
        a_vld = 1'b0; a = 2'd1;
        checks++;
        if (y !== 4'b0100 || idx !== 2'd2) begin
            errors++;
            $display("FAIL decode_load: y=%b idx=%0d required 0100/2", y, idx);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (y !== 4'b0100 || idx !== 2'd2 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL decode_hold[%0d]: y=%b idx=%0d wrap=%b required 0100/2/0", i, y, idx, wrap);
            end
        end
    endtask

    task automatic test_scan_wrap();
        logic [3:0] exp_y [5];
        logic       exp_w [5];
        exp_y = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        exp_w = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        mode = 1'b1; dwell = 4'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (y !== exp_y[i] || wrap !== exp_w[i]) begin
                errors++;
                $display("FAIL scan_wrap[%0d]: y=%b wrap=%b required %b/%b", i, y, wrap, exp_y[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_dwell();
        logic [3:0] exp_y [15];
        exp_y = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                  4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001};
        dwell = 4'd2; a = 2'd0; a_vld = 1'b1;
        step();
        a_vld = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) step();
            checks++;
            if (y !== exp_y[k] || wrap !== (k == 12)) begin
                errors++;
                $display("FAIL dwell[%0d]: y=%b wrap=%b required %b/%b", k, y, wrap, exp_y[k], (k == 12));
            end
        end
    endtask

    task automatic test_load_vs_advance();
        dwell = 4'd0; a = 2'd3; a_vld = 1'b1;
        step();
        checks++;
        if (y !== 4'b1000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL resync: y=%b wrap=%b required 1000/0", y, wrap);
        end
        a = 2'd1;
        step();
        a_vld = 1'b0;
        checks++;
        if (y !== 4'b0010 || idx !== 2'd1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_wins: y=%b idx=%0d wrap=%b required 0010/1/0", y, idx, wrap);
        end
        step();
        checks++;
        if (y !== 4'b0100 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL after_load: y=%b wrap=%b required 0100/0", y, wrap);
        end
    endtask

    task automatic test_enable_drop();
        step();
        checks++;
        if (y !== 4'b1000 || idx !== 2'd3) begin
            errors++;
            $display("FAIL reach_idx3: y=%b idx=%0d required 1000/3", y, idx);
        end
        en = 1'b0;
        step();
        checks++;
        if (y !== 4'b0000 || wrap !== 1'b0 || idx !== 2'd3) begin
            errors++;
            $display("FAIL en_drop: y=%b wrap=%b idx=%0d required 0000/0/3", y, wrap, idx);
        end
        a = 2'd0; a_vld = 1'b1;
        step();
        a_vld = 1'b0;
        checks++;
        if (y !== 4'b0000 || idx !== 2'd3) begin
            errors++;
            $display("FAIL avld_while_off: y=%b idx=%0d required 0000/3", y, idx);
        end
        dwell = 4'd1; en = 1'b1;
        step();
        checks++;
        if (y !== 4'b1000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reenable: y=%b wrap=%b required 1000/0", y, wrap);
        end
        step();
        checks++;
        if (y !== 4'b1000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reenable_dwell_hold: y=%b wrap=%b required 1000/0", y, wrap);
        end
        step();
        checks++;
        if (y !== 4'b0001 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL reenable_advance: y=%b wrap=%b required 0001/1", y, wrap);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (y !== 4'b0000 || idx !== 2'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL mid_scan_reset: y=%b idx=%0d wrap=%b required 0000/0/0", y, idx, wrap);
        end
    endtask

    task automatic test_scan_to_decode();
        en = 1'b1; mode = 1'b1; dwell = 4'd0;
        step();
        step();
        checks++;
        if (y !== 4'b0010 || idx !== 2'd1) begin
            errors++;
            $display("FAIL scan_from_idle: y=%b idx=%0d required 0010/1", y, idx);
        end
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (y !== 4'b0010 || idx !== 2'd1 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL scan_to_decode[%0d]: y=%b idx=%0d wrap=%b required 0010/1/0", i, y, idx, wrap);
            end
        end
    endtask

`ifdef DEC_SCAN_BIDIR_EN
    task automatic test_bidir();
        logic [3:0] exp_y [3];
        logic       exp_w [3];
        exp_y = '{4'b0010, 4'b0001, 4'b1000};
        exp_w = '{1'b0, 1'b0, 1'b1};
        dir = 1'b1; dwell = 4'd0; mode = 1'b0; a = 2'd1; a_vld = 1'b1;
        step();
        a_vld = 1'b0; mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (y !== exp_y[i] || wrap !== exp_w[i]) begin
                errors++;
                $display("FAIL bidir[%0d]: y=%b wrap=%b required %b/%b", i, y, wrap, exp_y[i], exp_w[i]);
            end
        end
        dir = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; a = 2'd0; a_vld = 1'b0;
        dwell = 4'd0; dir = 1'b0;
        #1;
        test_reset();
        test_decode();
        test_scan_wrap();
        test_dwell();
        test_load_vs_advance();
        test_enable_drop();
        test_scan_to_decode();
`ifdef DEC_SCAN_BIDIR_EN
        test_bidir();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
